// File: rtl/matrix_engine_pkg.sv
// Shared definitions for the matrix engine: element geometry, bus device IDs,
// clear-sequencer states and row/column to flat-element index mapping.
package matrix_engine_pkg;

  localparam int unsigned ELEM_W_DEF = 16;
  localparam int unsigned DIM_DEF    = 4;

  // addressBus[15:12] device select codes
  localparam logic [3:0] DEV_ID_CTRL = 4'h1;
  localparam logic [3:0] DEV_ID_DMA  = 4'h2;
  localparam logic [3:0] DEV_ID_ALU  = 4'h3;
  localparam logic [3:0] DEV_ID_MRF  = 4'h4;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  function automatic int unsigned elem_index(input int unsigned row,
                                             input int unsigned col,
                                             input int unsigned dim);
    return row * dim + col;
  endfunction

endpackage

// File: rtl/matrix_transpose.sv
// Pure combinational DIM x DIM transpose of a row-major packed matrix.
module matrix_transpose
  import matrix_engine_pkg::*;
#(
  parameter int unsigned ELEM_W = ELEM_W_DEF,
  parameter int unsigned DIM    = DIM_DEF
) (
  input  logic [ELEM_W*DIM*DIM-1:0] in_mat,
  output logic [ELEM_W*DIM*DIM-1:0] out_mat
);

  for (genvar r = 0; r < DIM; r++) begin : g_row
    for (genvar c = 0; c < DIM; c++) begin : g_col
      assign out_mat[elem_index(r, c, DIM)*ELEM_W +: ELEM_W] =
             in_mat[elem_index(c, r, DIM)*ELEM_W +: ELEM_W];
    end
  end

endmodule

// File: rtl/matrix_register_file.sv
// Multi-entry matrix register file with element write mask, registered read,
// address-error pulse and sequenced clear-all. Optional: TRANSPOSE_READ_EN.
module matrix_register_file
  import matrix_engine_pkg::*;
#(
  parameter int unsigned ELEM_W    = ELEM_W_DEF,
  parameter int unsigned DIM       = DIM_DEF,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ADDR_W    = 16,
  parameter logic [3:0]  DEVICE_ID = DEV_ID_MRF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ELEM_W*DIM*DIM-1:0]  inputDataBus,
  input  logic [ADDR_W-1:0]          addressBus,
  input  logic                       writeToReg,
  input  logic                       readFromReg,
  input  logic [DIM*DIM-1:0]         elemMask,
  input  logic                       clearAll,
`ifdef TRANSPOSE_READ_EN
  input  logic                       readTranspose,
`endif
  output logic [ELEM_W*DIM*DIM-1:0]  outputDataBus,
  output logic                       readValid,
  output logic                       addrError,
  output logic                       busy
);

  localparam int unsigned DATA_W   = ELEM_W * DIM * DIM;
  localparam int unsigned NE       = DIM * DIM;
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [12:0] DEPTH_L  = 13'(DEPTH);
  localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  clr_state_e        state_q;
  logic [AW-1:0]     cnt_q;
  logic              busy_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              aerr_q, aerr_d;

  logic              sel_s, in_range_s, idle_s, rd_req_s, wr_req_s;
  logic [11:0]       idx_s;
  logic [AW-1:0]     ent_s;
  logic              wr_en_s;
  logic [AW-1:0]     wr_idx_s;
  logic [DATA_W-1:0] wr_data_s;
  logic [NE-1:0]     wr_mask_s;
  logic [DATA_W-1:0] rd_raw_s, rd_view_s;

  always_comb begin
    sel_s      = (addressBus[ADDR_W-1 -: 4] == DEVICE_ID);
    idx_s      = addressBus[11:0];
    ent_s      = idx_s[AW-1:0];
    in_range_s = ({1'b0, idx_s} < DEPTH_L);
    idle_s     = (state_q == IDLE);
    rd_req_s   = idle_s && readFromReg && sel_s;
    // clearAll in the same cycle as a write takes priority over it
    wr_req_s   = idle_s && writeToReg && sel_s && !clearAll;
  end

  // The clear sequencer owns the single write port while it runs.
  always_comb begin
    if (!idle_s) begin
      wr_en_s   = 1'b1;
      wr_idx_s  = cnt_q;
      wr_data_s = '0;
      wr_mask_s = '1;
    end else begin
      wr_en_s   = wr_req_s && in_range_s;
      wr_idx_s  = ent_s;
      wr_data_s = inputDataBus;
      wr_mask_s = elemMask;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int k = 0; k < NE; k++) begin
        if (wr_mask_s[k]) begin
          mem_q[wr_idx_s][k*ELEM_W +: ELEM_W] <= wr_data_s[k*ELEM_W +: ELEM_W];
        end
      end
    end
  end

  assign rd_raw_s = mem_q[ent_s];

`ifdef TRANSPOSE_READ_EN
  logic [DATA_W-1:0] rd_tr_s;

  matrix_transpose #(.ELEM_W(ELEM_W), .DIM(DIM)) u_transpose (
    .in_mat (rd_raw_s),
    .out_mat(rd_tr_s)
  );

  assign rd_view_s = readTranspose ? rd_tr_s : rd_raw_s;
`else
  assign rd_view_s = rd_raw_s;
`endif

  always_comb begin
    rvalid_d = rd_req_s && in_range_s;
    aerr_d   = (rd_req_s || wr_req_s) && !in_range_s;
    if (rvalid_d) begin
      rdata_d = rd_view_s;
    end else begin
      rdata_d = rdata_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clearAll) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        CLEAR: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      aerr_q   <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      aerr_q   <= aerr_d;
    end
  end

  assign outputDataBus = rdata_q;
  assign readValid     = rvalid_q;
  assign addrError     = aerr_q;
  assign busy          = busy_q;

endmodule
